// File: rtl/wdt_timeout_ctrl.sv
// Watchdog timeout controller: a prescaled tick counter that sequences
// disable / count / expire. It latches the timeout limit on enable and on
// every kick, and drives a registered timeout level, an entry pulse and an
// early warning.
module wdt_timeout_ctrl #(
    parameter int PRESCALE    = 16,
    parameter int CNT_W       = 32,
    parameter int WARN_MARGIN = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             WDEN,
    input  logic             WDLIVE,
    input  logic [CNT_W-1:0] WTOCNT,
    output logic             WTO,
    output logic             WTO_PULSE,
    output logic             WARN,
    output logic [1:0]       WDT_STATE,
    output logic [CNT_W-1:0] WDT_CNT
);

    // A prescale of 1 still needs a one-bit register so the vector is legal.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_COUNT    = 2'b01,
        ST_EXPIRED  = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] limit_reg, limit_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic             live_d_reg;
    logic             pulse_reg, pulse_next;

    logic             kick;
    logic             tick;
    logic             expire_hit;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   limit_eff;
    logic [CNT_W-1:0] remaining;

    assign kick = WDLIVE & ~live_d_reg;
    assign tick = (state_reg == ST_COUNT) && (pre_reg == PRE_LAST);

    // The increment is one bit wider, so an all-ones limit can never wrap
    // the compare. A zero limit expires on the first tick, like a limit of 1.
    assign cnt_inc    = {1'b0, cnt_reg} + (CNT_W+1)'(1);
    assign limit_eff  = (limit_reg == '0) ? (CNT_W+1)'(1) : {1'b0, limit_reg};
    assign expire_hit = (cnt_inc >= limit_eff);

    // cnt never exceeds limit while counting, so this difference cannot underflow.
    assign remaining  = limit_reg - cnt_reg;

    assign WTO       = (state_reg == ST_EXPIRED);
    assign WTO_PULSE = pulse_reg;
    assign WARN      = (state_reg == ST_COUNT) && (remaining <= CNT_W'(WARN_MARGIN));
    assign WDT_STATE = state_reg;
    assign WDT_CNT   = cnt_reg;

    // Next-state logic. Inside COUNT the order is: disable, then kick, then tick.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        limit_next = limit_reg;
        pre_next   = '0;
        pulse_next = 1'b0;
        case (state_reg)
            ST_DISABLED: begin
                cnt_next = '0;
                if (WDEN) begin
                    state_next = ST_COUNT;
                    limit_next = WTOCNT;
                end
            end
            ST_COUNT: begin
                pre_next = tick ? '0 : pre_reg + PRE_W'(1);
                if (!WDEN) begin
                    state_next = ST_DISABLED;
                    cnt_next   = '0;
                    pre_next   = '0;
                end else if (kick) begin
                    cnt_next   = '0;
                    pre_next   = '0;
                    limit_next = WTOCNT;
                end else if (tick) begin
                    if (expire_hit) begin
                        state_next = ST_EXPIRED;
                        pulse_next = 1'b1;
                    end else begin
                        cnt_next = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            ST_EXPIRED: begin
                if (!WDEN) begin
                    state_next = ST_DISABLED;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_DISABLED;
                cnt_next   = '0;
            end
        endcase
    end

    // State registers. Reset drops the timeout immediately, without a clock edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg  <= ST_DISABLED;
            cnt_reg    <= '0;
            limit_reg  <= '1;
            pre_reg    <= '0;
            live_d_reg <= 1'b0;
            pulse_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            limit_reg  <= limit_next;
            pre_reg    <= pre_next;
            live_d_reg <= WDLIVE;
            pulse_reg  <= pulse_next;
        end
    end

endmodule

// File: tb/tb_wdt_timeout_ctrl.sv
// Bench for wdt_timeout_ctrl. Two instances (prescale 1 and 4) share one
// stimulus stream. A timeline model predicts each instance's outputs from the
// edge of the last enable or kick, using plain arithmetic.
module tb_wdt_timeout_ctrl;

    logic        CLK;
    logic        RSTn;
    logic        WDEN;
    logic        WDLIVE;
    logic [31:0] WTOCNT;

    logic        wto_p1, pulse_p1, warn_p1;
    logic [1:0]  st_p1;
    logic [31:0] cnt_p1;
    logic        wto_p4, pulse_p4, warn_p4;
    logic [1:0]  st_p4;
    logic [31:0] cnt_p4;
    logic [36:0] obs0, obs1;

    int vectors;
    int miscompares;

    // Model state: 0 off, 1 running, 2 expired; edge index of the last restart.
    int          m_state [2];
    longint      m_start [2];
    longint      m_lim   [2];
    bit          m_pulse [2];
    bit          live_prev;
    longint      edge_n;

    wdt_timeout_ctrl #(.PRESCALE(1), .CNT_W(32), .WARN_MARGIN(8)) dut_p1 (
        .CLK(CLK), .RSTn(RSTn), .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT),
        .WTO(wto_p1), .WTO_PULSE(pulse_p1), .WARN(warn_p1),
        .WDT_STATE(st_p1), .WDT_CNT(cnt_p1)
    );

    wdt_timeout_ctrl #(.PRESCALE(4), .CNT_W(32), .WARN_MARGIN(8)) dut_p4 (
        .CLK(CLK), .RSTn(RSTn), .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT),
        .WTO(wto_p4), .WTO_PULSE(pulse_p4), .WARN(warn_p4),
        .WDT_STATE(st_p4), .WDT_CNT(cnt_p4)
    );

    assign obs0 = {wto_p1, pulse_p1, warn_p1, st_p1, cnt_p1};
    assign obs1 = {wto_p4, pulse_p4, warn_p4, st_p4, cnt_p4};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic longint pval(input int i);
        return (i == 0) ? 64'd1 : 64'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_start[i] = 0;
            m_lim[i]   = 64'h0000_0000_FFFF_FFFF;
            m_pulse[i] = 1'b0;
        end
        live_prev = 1'b0;
        edge_n    = 0;
    endtask

    // Advance the model by one clock edge, using the inputs that edge samples.
    task automatic model_step();
        bit     kick;
        longint eff;
        edge_n++;
        kick      = WDLIVE && !live_prev;
        live_prev = WDLIVE;
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 1'b0;
            eff = (m_lim[i] == 0) ? 64'd1 : m_lim[i];
            if (m_state[i] == 0) begin
                if (WDEN) begin
                    m_state[i] = 1;
                    m_start[i] = edge_n;
                    m_lim[i]   = longint'(WTOCNT);
                end
            end else if (m_state[i] == 1) begin
                if (!WDEN) begin
                    m_state[i] = 0;
                end else if (kick) begin
                    m_start[i] = edge_n;
                    m_lim[i]   = longint'(WTOCNT);
                end else if (edge_n == m_start[i] + pval(i) * eff) begin
                    m_state[i] = 2;
                    m_pulse[i] = 1'b1;
                end
            end else begin
                if (!WDEN) m_state[i] = 0;
            end
        end
    endtask

    function automatic logic [36:0] model_out(input int i);
        longint c;
        logic   w;
        c = 0;
        w = 1'b0;
        if (m_state[i] == 1) begin
            c = (edge_n - m_start[i]) / pval(i);
            w = ((m_lim[i] - c) <= 8);
        end else if (m_state[i] == 2) begin
            c = ((m_lim[i] == 0) ? 64'd1 : m_lim[i]) - 1;
        end
        return {(m_state[i] == 2), m_pulse[i], w, 2'(m_state[i]), c[31:0]};
    endfunction

    // Drive one cycle of inputs right after a falling edge, predict, then wait.
    task automatic step(input logic en, input logic live, input logic [31:0] tocnt);
        WDEN   = en;
        WDLIVE = live;
        WTOCNT = tocnt;
        if (RSTn) model_step();
        else      model_reset();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        vectors++;
        if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
            miscompares++;
            $display("FAIL reset: got p1=%h p4=%h expected p1=%h p4=%h", obs0, obs1, model_out(0), model_out(1));
        end
        RSTn = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_expire_basic();
        int first1, first4, pulses1;
        first1 = -1; first4 = -1; pulses1 = 0;
        for (int s = 1; s <= 26; s++) begin
            step(1'b1, 1'b0, 32'd5);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL expire_basic edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (wto_p1 && first1 < 0) first1 = s;
            if (wto_p4 && first4 < 0) first4 = s;
            if (pulse_p1) pulses1++;
        end
        vectors++;
        if (first1 !== 6) begin
            miscompares++;
            $display("FAIL expire_p1_latency: got step %0d expected step 6", first1);
        end
        vectors++;
        if (first4 !== 21) begin
            miscompares++;
            $display("FAIL expire_p4_latency: got step %0d expected step 21", first4);
        end
        vectors++;
        if (pulses1 !== 1) begin
            miscompares++;
            $display("FAIL expire_pulse_count: got %0d expected 1", pulses1);
        end
        for (int s = 0; s < 2; s++) begin
            step(1'b0, 1'b0, 32'd5);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL expire_disable edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
        end
        $display("test_expire_basic done");
    endtask

    task automatic test_kick();
        int   next_kick, last_kick, rise_at;
        logic live;
        bit   p4_seen;
        next_kick = $urandom_range(20, 35);
        last_kick = 0; rise_at = -1; p4_seen = 1'b0;
        for (int s = 0; s < 400; s++) begin
            live = (s >= next_kick) && (s < next_kick + 3);
            if (s == next_kick) last_kick = s;
            if (s == next_kick + 3) next_kick = s + $urandom_range(17, 32);
            step(1'b1, live, 32'd10);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL kick edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (wto_p4) p4_seen = 1'b1;
        end
        vectors++;
        if (p4_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL kick_keepalive: got WTO=1 expected WTO=0 while kicked");
        end
        for (int k = 0; k < 80 && rise_at < 0; k++) begin
            step(1'b1, 1'b0, 32'd10);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL kick_stop edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (wto_p4) rise_at = 400 + k;
        end
        vectors++;
        if (rise_at - last_kick !== 40) begin
            miscompares++;
            $display("FAIL kick_stop_latency: got %0d cycles expected 40", rise_at - last_kick);
        end
        step(1'b0, 1'b0, 32'd10);
        $display("test_kick done, last kick at step %0d", last_kick);
    endtask

    task automatic test_live_held();
        for (int s = 0; s < 120; s++) begin
            step(1'b1, (s >= 10) && (s < 110), 32'd200);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL live_held edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
        end
        vectors++;
        if ({cnt_p1, cnt_p4} !== {32'd109, 32'd27}) begin
            miscompares++;
            $display("FAIL live_held_single_reload: got cnt %0d/%0d expected 109/27", cnt_p1, cnt_p4);
        end
        step(1'b0, 1'b0, 32'd3);
        $display("test_live_held done");
    endtask

    task automatic test_same_edge();
        for (int s = 0; s < 8; s++) begin
            step(1'b1, (s >= 3), 32'd3);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL same_edge edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (s == 3) begin
                vectors++;
                if ({st_p1, cnt_p1} !== {2'b01, 32'd0}) begin
                    miscompares++;
                    $display("FAIL same_edge_kick_wins: got state %b cnt %0d expected state 01 cnt 0", st_p1, cnt_p1);
                end
            end
        end
        step(1'b0, 1'b0, 32'd3);
        $display("test_same_edge done");
    endtask

    task automatic test_expired_kick();
        int first1, first4;
        for (int s = 0; s < 15; s++) begin
            step(1'b1, 1'b0, 32'd3);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL expired_run edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
        end
        for (int s = 0; s < 2; s++) begin
            step(1'b1, 1'b1, 32'd3);
            vectors++;
            if ({wto_p1, wto_p4} !== 2'b11) begin
                miscompares++;
                $display("FAIL expired_kick_ignored: got WTO %b expected 11", {wto_p1, wto_p4});
            end
        end
        step(1'b0, 1'b0, 32'd3);
        vectors++;
        if ({wto_p1, wto_p4, st_p1, st_p4} !== 6'b00_0000) begin
            miscompares++;
            $display("FAIL expired_disable: got WTO %b state %b/%b expected 00 00/00", {wto_p1, wto_p4}, st_p1, st_p4);
        end
        first1 = -1; first4 = -1;
        for (int s = 0; s < 12; s++) begin
            step(1'b1, 1'b0, (s >= 2) ? 32'd100 : 32'd2);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL reenable edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (wto_p1 && first1 < 0) first1 = s;
            if (wto_p4 && first4 < 0) first4 = s;
        end
        vectors++;
        if ({first1, first4} !== {32'sd2, 32'sd8}) begin
            miscompares++;
            $display("FAIL reenable_latency: got steps %0d/%0d expected 2/8", first1, first4);
        end
        step(1'b0, 1'b0, 32'd4);
        first1 = -1;
        for (int s = 0; s < 13; s++) begin
            step(1'b1, (s == 3), (s >= 2) ? 32'd6 : 32'd4);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL reload edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (wto_p1 && first1 < 0) first1 = s;
        end
        vectors++;
        if (first1 !== 9) begin
            miscompares++;
            $display("FAIL reload_new_limit: got step %0d expected step 9", first1);
        end
        step(1'b0, 1'b0, 32'd20);
        $display("test_expired_kick done");
    endtask

    task automatic test_warn_reset();
        for (int s = 0; s < 15; s++) begin
            step(1'b1, 1'b0, 32'd20);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL warn edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if (s == 11 || s == 12) begin
                vectors++;
                if (warn_p1 !== (s == 12)) begin
                    miscompares++;
                    $display("FAIL warn_threshold cnt %0d: got %b expected %b", cnt_p1, warn_p1, (s == 12));
                end
            end
        end
        #2 RSTn = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({obs0, obs1} !== 74'd0) begin
            miscompares++;
            $display("FAIL async_reset: got p1=%h p4=%h expected all zero", obs0, obs1);
        end
        @(negedge CLK);
        step(1'b1, 1'b0, 32'd20);
        vectors++;
        if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
            miscompares++;
            $display("FAIL reset_held: got p1=%h p4=%h expected p1=%h p4=%h", obs0, obs1, model_out(0), model_out(1));
        end
        RSTn = 1'b1;
        step(1'b0, 1'b0, 32'd20);
        $display("test_warn_reset done");
    endtask

    task automatic test_random();
        logic        en, live;
        logic [31:0] tocnt;
        en = 1'b1; live = 1'b0; tocnt = 32'd6;
        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) live = ~live;
            if ($urandom_range(0, 15) == 0) tocnt = 32'hFFFF_FFFF;
            else if ($urandom_range(0, 3) == 0) tocnt = $urandom_range(0, 12);
            step(en, live, tocnt);
            vectors++;
            if ({obs0, obs1} !== {model_out(0), model_out(1)}) begin
                miscompares++;
                $display("FAIL random edge %0d: got p1=%h p4=%h expected p1=%h p4=%h", edge_n, obs0, obs1, model_out(0), model_out(1));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 RSTn = 1'b0;
                model_reset();
                #1;
                vectors++;
                if ({obs0, obs1} !== 74'd0) begin
                    miscompares++;
                    $display("FAIL random_reset: got p1=%h p4=%h expected all zero", obs0, obs1);
                end
                @(negedge CLK);
                RSTn = 1'b1;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RSTn   = 1'b0;
        WDEN   = 1'b0;
        WDLIVE = 1'b0;
        WTOCNT = 32'd0;
        model_reset();
        repeat (2) @(negedge CLK);
        test_reset();
        test_expire_basic();
        test_kick();
        test_live_held();
        test_same_edge();
        test_expired_kick();
        test_warn_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
